pack_round16: RTL

Result packer/rounder for the fma16 datapath, the inverse of operand unpacking. Accepts an unnormalized signed-exponent/wide-mantissa result with special-case flags, then normalizes, handles subnormal denormalization, rounds per IEEE 754 mode and packs a 16-bit binary16 word plus exception flags. Multi-cycle FSM with valid/ready handshakes on both sides; sits between the FMA add/LZA stage and the result register.

---
 rtl/pack_round16.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/pack_round16.sv
// Normalize, round and pack an fma16 result into binary16 via a 4-state FSM (IDLE/NORM/ROUND/DONE).
// Define PACK_ROUND16_FLAGS_EN to compute exception flags; otherwise flags is held at 4'b0000.
module pack_round16 (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        Zs,
  input  logic [7:0]  Ze,
  input  logic [21:0] Zm,
  input  logic        Zsticky,
  input  logic        ZNaN,
  input  logic        ZInf,
  input  logic        Zinvalid,
  input  logic [1:0]  rm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] R,
  output logic [3:0]  flags,
  output logic [1:0]  dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both high;
  // in_ready is high only in IDLE, and out_valid/R/flags hold steady until out_ready.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_NORM  = 2'd1,
    S_ROUND = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] RM_RNE = 2'b00;
  localparam logic [1:0] RM_RZ  = 2'b01;
  localparam logic [1:0] RM_RDN = 2'b10;
  localparam logic [1:0] RM_RUP = 2'b11;

  state_t      r_state;

  logic        r_zs;
  logic [7:0]  r_ze;
  logic [21:0] r_zm;
  logic        r_zsticky;
  logic        r_znan;
  logic        r_zinf;
  logic        r_zinv;
  logic [1:0]  r_rm;

  logic [9:0]  r_frac;
  logic [4:0]  r_expf;
  logic        r_g;
  logic        r_s;
  logic        r_tiny;
  logic        r_ovf_pre;

  logic [4:0]        w_lead;
  logic [21:0]       w_norm;
  logic signed [8:0] w_e;
  logic [8:0]        w_sh;
  logic [4:0]        w_sh_sat;
  logic [44:0]       w_wide;
  logic              w_denorm;
  logic [4:0]        w_expf;
  logic              w_ovf_pre;

  // NORM datapath: left-justify the mantissa, then right-shift into the subnormal range if needed.
  always_comb begin
    w_lead = 5'd0;
    for (int i = 0; i < 22; i++) begin
      if (r_zm[i]) w_lead = 5'(i);
    end
    w_norm    = r_zm << (5'd21 - w_lead);
    w_e       = $signed({r_ze[7], r_ze}) + $signed({4'b0000, w_lead}) - 9'sd20;
    w_denorm  = w_e[8] || (w_e == 9'sd0);
    w_sh      = 9'd1 - w_e;
    w_sh_sat  = 5'd0;
    w_expf    = w_e[4:0];
    w_ovf_pre = 1'b0;
    if (w_denorm) begin
      w_sh_sat = (w_sh > 9'd23) ? 5'd23 : w_sh[4:0];
      w_expf   = 5'd0;
    end else begin
      w_ovf_pre = (w_e[7:0] >= 8'd31);
    end
    w_wide = {w_norm, 23'b0} >> w_sh_sat;
  end

  logic        w_inc;
  logic [14:0] w_sum;
  logic        w_ovf;
  logic        w_zero;
  logic        w_special;
  logic [15:0] w_ovf_res;
  logic [15:0] w_res;
  logic [3:0]  w_flags;

  always_comb begin
    w_inc = 1'b0;
    unique case (r_rm)
      RM_RNE: w_inc = r_g & (r_s | r_frac[0]);
      RM_RZ:  w_inc = 1'b0;
      RM_RDN: w_inc = r_zs & (r_g | r_s);
      RM_RUP: w_inc = ~r_zs & (r_g | r_s);
      default: w_inc = 1'b0;
    endcase
    // The carry out of the fraction walks into the exponent field for free.
    w_sum = {r_expf, r_frac} + {14'd0, w_inc};
    w_ovf = r_ovf_pre | (w_sum[14:10] == 5'h1F);

    w_ovf_res = {r_zs, 15'h7C00};
    unique case (r_rm)
      RM_RNE: w_ovf_res = {r_zs, 15'h7C00};
      RM_RZ:  w_ovf_res = {r_zs, 15'h7BFF};
      RM_RDN: w_ovf_res = r_zs ? 16'hFC00 : 16'h7BFF;
      RM_RUP: w_ovf_res = r_zs ? 16'hFBFF : 16'h7C00;
      default: w_ovf_res = {r_zs, 15'h7C00};
    endcase

    w_zero    = (r_zm == 22'd0) && !r_zsticky;
    w_special = r_znan | r_zinf | w_zero;
    if (r_znan)      w_res = 16'h7E00;
    else if (r_zinf) w_res = {r_zs, 15'h7C00};
    else if (w_zero) w_res = {r_zs, 15'h0000};
    else if (w_ovf)  w_res = w_ovf_res;
    else             w_res = {r_zs, w_sum};
  end

`ifdef PACK_ROUND16_FLAGS_EN
  logic w_ovf_flag;
  logic w_inexact;

  always_comb begin
    w_ovf_flag = w_ovf & ~w_special;
    w_inexact  = (r_g | r_s | w_ovf) & ~w_special;
    w_flags    = {r_zinv, w_ovf_flag, r_tiny & w_inexact, w_inexact};
  end

  logic w_unused;
  assign w_unused = w_wide[44];
`else
  assign w_flags = 4'b0000;

  logic w_unused;
  assign w_unused = &{1'b0, w_wide[44], r_tiny, r_zinv, w_special};
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      out_valid <= 1'b0;
      R         <= 16'h0000;
      flags     <= 4'b0000;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_zs      <= Zs;
            r_ze      <= Ze;
            r_zm      <= Zm;
            r_zsticky <= Zsticky;
            r_znan    <= ZNaN;
            r_zinf    <= ZInf;
            r_zinv    <= Zinvalid;
            r_rm      <= rm;
            r_state   <= S_NORM;
          end
        end
        S_NORM: begin
          r_frac    <= w_wide[43:34];
          r_g       <= w_wide[33];
          r_s       <= (|w_wide[32:0]) | r_zsticky;
          r_expf    <= w_expf;
          r_tiny    <= w_denorm;
          r_ovf_pre <= w_ovf_pre;
          r_state   <= S_ROUND;
        end
        S_ROUND: begin
          R         <= w_res;
          flags     <= w_flags;
          out_valid <= 1'b1;
          r_state   <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign dbg_state = r_state;

endmodule
